pu_or1k_rf_multiport: RTL and testbench



---
 rtl/pu_or1k_rf_multiport.sv | 128 ++++++++++++
 tb/tb_pu_or1k_rf_multiport.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pu_or1k_rf_multiport.sv
// pu_or1k_rf_multiport: banked multi-port GPR file with registered reads, write-through bypass,
// stage forwarding, clear-on-reset sequencer and handshaked SPR access.
module pu_or1k_rf_multiport #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int NUM_CONTEXTS = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int CW = NUM_CONTEXTS > 1 ? $clog2(NUM_CONTEXTS) : 1,
  localparam int FP = NUM_FWD_STAGES > 0 ? NUM_FWD_STAGES : 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [CW-1:0]                                    ctx_i,
  input  logic [NUM_READ_PORTS-1:0]                        rd_en_i,
  input  logic [NUM_READ_PORTS*OPTION_RF_ADDR_WIDTH-1:0]   rd_adr_i,
  output logic [NUM_READ_PORTS*OPTION_OPERAND_WIDTH-1:0]   rd_dat_o,
  input  logic [FP-1:0]                                    fwd_valid_i,
  input  logic [FP*OPTION_RF_ADDR_WIDTH-1:0]               fwd_adr_i,
  input  logic [FP*OPTION_OPERAND_WIDTH-1:0]               fwd_dat_i,
  input  logic                                             wr_en_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                  wr_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                  wr_dat_i,
  input  logic [15:0]                                      spr_bus_addr_i,
  input  logic                                             spr_bus_stb_i,
  input  logic                                             spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                  spr_bus_dat_i,
  output logic                                             spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]                  spr_gpr_dat_o,
  output logic                                             init_busy_o
);
  localparam int W = OPTION_OPERAND_WIDTH;
  localparam int AW = OPTION_RF_ADDR_WIDTH;
  localparam int R = NUM_READ_PORTS;
  localparam int F = NUM_FWD_STAGES;
  localparam int DEPTH = NUM_CONTEXTS << AW;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} seq_e;
  typedef enum logic [1:0] {IDLE, RDWAIT, ACK} spr_e;
  logic [W-1:0] mem [DEPTH];
  seq_e seq_q, seq_d;
  spr_e spr_q, spr_d;
  logic [PW-1:0] clr_q, clr_d, sadr_q, sadr_d, widx, spr_idx;
  logic [W-1:0] sdat_q, sdat_d, wdat;
  logic [W-1:0] hold_q [R];
  logic [W-1:0] hold_d [R];
  logic [PW-1:0] hidx_q [R];
  logic [PW-1:0] hidx_d [R];
  logic busy, spr_gpr, spr_wr, rd_req, wb, we, unused_bits;
  assign unused_bits = ^spr_bus_addr_i;
  assign spr_idx = spr_bus_addr_i[PW-1:0];
  assign init_busy_o = busy;
  assign spr_gpr_dat_o = sdat_q;
  // Single array write port: clear sequencer, then writeback, then SPR (SPR only when writeback idle)
  always_comb begin
    busy = seq_q == CLEAR;
    spr_gpr = spr_bus_stb_i && spr_bus_addr_i[15:9] == 7'h2 && !busy;
    wb = wr_en_i && !busy;
    spr_wr = spr_gpr && spr_bus_we_i && !wr_en_i;
    rd_req = spr_gpr && !spr_bus_we_i;
    we = busy || wb || spr_wr;
    widx = busy ? clr_q : wb ? PW'({ctx_i, wr_adr_i}) : spr_idx;
    wdat = busy ? '0 : wb ? wr_dat_i : spr_bus_dat_i;
    seq_d = busy && clr_q == PW'(DEPTH - 1) ? RUN : seq_q;
    clr_d = busy ? clr_q + 1'b1 : clr_q;
  end
  // A held port tracks writes to its index, so a stalled operand stays coherent
  always_comb begin
    for (int p = 0; p < R; p++) begin
      hidx_d[p] = rd_en_i[p] ? PW'({ctx_i, rd_adr_i[p*AW +: AW]}) : hidx_q[p];
      hold_d[p] = busy ? '0 : (we && widx == hidx_d[p]) ? wdat : rd_en_i[p] ? mem[hidx_d[p]] : hold_q[p];
    end
  end
  always_comb begin
    rd_dat_o = '0;
    for (int p = 0; p < R; p++) begin
      rd_dat_o[p*W +: W] = hold_q[p];
      for (int i = F - 1; i >= 0; i--)
        if (fwd_valid_i[i] && PW'({ctx_i, fwd_adr_i[i*AW +: AW]}) == hidx_q[p])
          rd_dat_o[p*W +: W] = fwd_dat_i[i*W +: W];
    end
    if (busy) rd_dat_o = '0;
  end
  always_comb begin
    spr_d = spr_q;
    sadr_d = sadr_q;
    sdat_d = sdat_q;
    unique case (spr_q)
      IDLE: begin
        spr_d = rd_req ? RDWAIT : IDLE;
        sadr_d = rd_req ? spr_idx : sadr_q;
      end
      RDWAIT: begin
        spr_d = rd_req ? ACK : IDLE;
        sdat_d = !rd_req ? sdat_q : (we && widx == sadr_q) ? wdat : mem[sadr_q];
      end
      ACK: spr_d = rd_req ? ACK : IDLE;
      default: spr_d = IDLE;
    endcase
    spr_gpr_ack_o = spr_wr || (spr_q == ACK && rd_req);
  end
  always_ff @(posedge clk)
    if (we) mem[widx] <= wdat;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= CLEAR_ON_RESET != 0 ? CLEAR : RUN;
      clr_q <= '0;
      spr_q <= IDLE;
      sadr_q <= '0;
      sdat_q <= '0;
      for (int p = 0; p < R; p++) begin
        hold_q[p] <= '0;
        hidx_q[p] <= '0;
      end
    end else begin
      seq_q <= seq_d;
      clr_q <= clr_d;
      spr_q <= spr_d;
      sadr_q <= sadr_d;
      sdat_q <= sdat_d;
      for (int p = 0; p < R; p++) begin
        hold_q[p] <= hold_d[p];
        hidx_q[p] <= hidx_d[p];
      end
    end
  end
endmodule

// File: tb/tb_pu_or1k_rf_multiport.sv
// tb_pu_or1k_rf_multiport: directed vectors with hand-computed expectations, 2 ports, 2 forwarding stages, 2 contexts.
module tb_pu_or1k_rf_multiport;
  logic clk = 0, rst_n = 0;
  logic [0:0] ctx_i = '0;
  logic [1:0] rd_en_i = '0;
  logic [9:0] rd_adr_i = '0;
  logic [63:0] rd_dat_o;
  logic [1:0] fwd_valid_i = '0;
  logic [9:0] fwd_adr_i = '0;
  logic [63:0] fwd_dat_i = '0;
  logic wr_en_i = 0;
  logic [4:0] wr_adr_i = '0;
  logic [31:0] wr_dat_i = '0;
  logic [15:0] spr_bus_addr_i = '0;
  logic spr_bus_stb_i = 0, spr_bus_we_i = 0;
  logic [31:0] spr_bus_dat_i = '0;
  logic spr_gpr_ack_o, init_busy_o;
  logic [31:0] spr_gpr_dat_o;
  int n_run = 0, n_fail = 0, cnt;

  pu_or1k_rf_multiport #(
    .OPTION_OPERAND_WIDTH(32), .OPTION_RF_ADDR_WIDTH(5), .NUM_READ_PORTS(2),
    .NUM_FWD_STAGES(2), .NUM_CONTEXTS(2), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ctx_i(ctx_i), .rd_en_i(rd_en_i), .rd_adr_i(rd_adr_i),
    .rd_dat_o(rd_dat_o), .fwd_valid_i(fwd_valid_i), .fwd_adr_i(fwd_adr_i), .fwd_dat_i(fwd_dat_i),
    .wr_en_i(wr_en_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i), .spr_bus_addr_i(spr_bus_addr_i),
    .spr_bus_stb_i(spr_bus_stb_i), .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_gpr_ack_o(spr_gpr_ack_o), .spr_gpr_dat_o(spr_gpr_dat_o), .init_busy_o(init_busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en_i = '0; wr_en_i = 0; spr_bus_stb_i = 0; spr_bus_we_i = 0; fwd_valid_i = '0;
  endtask

  task automatic count_clear();
    cnt = 0;
    while (init_busy_o && cnt < 200) begin
      wr_en_i = cnt == 40; wr_adr_i = 5'd0; wr_dat_i = 32'hFFFF_FFFF;
      spr_bus_stb_i = cnt == 40; spr_bus_we_i = 1; spr_bus_addr_i = 16'h0401; spr_bus_dat_i = 32'h1;
      #1;
      if (cnt == 40) chk("clear_spr_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
      step();
      cnt++;
    end
    idle();
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", {31'd0, init_busy_o}, 32'd1);
    chk("rst_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    chk("rst_sprdat", spr_gpr_dat_o, 32'd0);
    chk("rst_rd0", rd_dat_o[31:0], 32'd0);
    chk("rst_rd1", rd_dat_o[63:32], 32'd0);
    rst_n = 1;
    repeat (30) step();
    chk("busy_c30", {31'd0, init_busy_o}, 32'd1);
    rst_n = 0;
    #1;
    chk("busy_rst_pulse", {31'd0, init_busy_o}, 32'd1);
    #1;
    rst_n = 1;
    count_clear();
    chk("clear_cycles", cnt, 32'd64);
    for (int a = 0; a < 64; a++) begin
      ctx_i = a[5]; rd_en_i = 2'b11;
      rd_adr_i = {5'(31 - a[4:0]), a[4:0]};
      step();
      chk("zero_p0", rd_dat_o[31:0], 32'd0);
      chk("zero_p1", rd_dat_o[63:32], 32'd0);
    end
    idle(); ctx_i = 0;
    wr_en_i = 1; wr_adr_i = 5'd3; wr_dat_i = 32'hDEADBEEF;
    rd_en_i = 2'b01; rd_adr_i = {5'd0, 5'd3};
    step(); idle();
    chk("wt_bypass", rd_dat_o[31:0], 32'hDEADBEEF);
    rd_en_i = 2'b10; rd_adr_i = {5'd7, 5'd0};
    step(); idle();
    chk("hold_r7_init", rd_dat_o[63:32], 32'd0);
    wr_en_i = 1; wr_adr_i = 5'd7; wr_dat_i = 32'h12345678;
    step(); idle();
    chk("hold_coherent", rd_dat_o[63:32], 32'h12345678);
    chk("hold_p0_kept", rd_dat_o[31:0], 32'hDEADBEEF);
    fwd_adr_i = {5'd7, 5'd7}; fwd_dat_i = {32'hBBBB0000, 32'hAAAA0000}; fwd_valid_i = 2'b11;
    #1 chk("fwd_both", rd_dat_o[63:32], 32'hAAAA0000);
    fwd_valid_i = 2'b10;
    #1 chk("fwd_older", rd_dat_o[63:32], 32'hBBBB0000);
    fwd_valid_i = 2'b00;
    #1 chk("fwd_none", rd_dat_o[63:32], 32'h12345678);
    fwd_adr_i = {5'd7, 5'd8}; fwd_valid_i = 2'b01;
    #1 chk("fwd_adr_miss", rd_dat_o[63:32], 32'h12345678);
    fwd_adr_i = {5'd7, 5'd7}; ctx_i = 1;
    #1 chk("fwd_ctx_miss", rd_dat_o[63:32], 32'h12345678);
    idle();
    wr_en_i = 1; wr_adr_i = 5'd4; wr_dat_i = 32'h55;
    step(); idle();
    ctx_i = 0; rd_en_i = 2'b01; rd_adr_i = {5'd0, 5'd4};
    step(); idle();
    chk("ctx0_r4", rd_dat_o[31:0], 32'd0);
    ctx_i = 1; rd_en_i = 2'b11; rd_adr_i = {5'd4, 5'd4};
    step(); idle();
    chk("ctx1_r4_p0", rd_dat_o[31:0], 32'h55);
    chk("ctx1_r4_p1", rd_dat_o[63:32], 32'h55);
    ctx_i = 0;
    spr_bus_addr_i = 16'h0424; spr_bus_we_i = 0; spr_bus_stb_i = 1;
    #1 chk("sprrd_c0_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    step();
    chk("sprrd_c1_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    step();
    chk("sprrd_c2_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    chk("sprrd_c2_dat", spr_gpr_dat_o, 32'h55);
    step();
    chk("sprrd_c3_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    spr_bus_stb_i = 0;
    #1 chk("sprrd_drop_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    step();
    spr_bus_addr_i = 16'h0403; spr_bus_stb_i = 1;
    step();
    spr_bus_stb_i = 0;
    step();
    chk("abort_c2_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    spr_bus_stb_i = 1;
    #1 chk("abort_restart_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    step();
    step();
    chk("abort_fresh_dat", spr_gpr_dat_o, 32'hDEADBEEF);
    idle();
    step();
    spr_bus_addr_i = 16'h0405; spr_bus_dat_i = 32'h99; spr_bus_we_i = 1; spr_bus_stb_i = 1;
    wr_adr_i = 5'd10; wr_dat_i = 32'h10101010;
    for (int c = 1; c <= 3; c++) begin
      wr_en_i = 1;
      #1 chk("sprwr_blocked", {31'd0, spr_gpr_ack_o}, 32'd0);
      step();
    end
    wr_en_i = 0;
    #1 chk("sprwr_c4_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    step(); idle();
    rd_en_i = 2'b11; rd_adr_i = {5'd10, 5'd5};
    step(); idle();
    chk("sprwr_r5", rd_dat_o[31:0], 32'h99);
    chk("wb_r10", rd_dat_o[63:32], 32'h10101010);
    wr_en_i = 1; wr_adr_i = 5'd6; wr_dat_i = 32'h1111;
    spr_bus_addr_i = 16'h0406; spr_bus_dat_i = 32'h2222; spr_bus_we_i = 1; spr_bus_stb_i = 1;
    #1 chk("collide_ack", {31'd0, spr_gpr_ack_o}, 32'd0);
    step(); idle();
    rd_en_i = 2'b01; rd_adr_i = {5'd0, 5'd6};
    step(); idle();
    chk("collide_wb_wins", rd_dat_o[31:0], 32'h1111);
    spr_bus_addr_i = 16'h0409; spr_bus_dat_i = 32'h77; spr_bus_we_i = 1; spr_bus_stb_i = 1;
    rd_en_i = 2'b01; rd_adr_i = {5'd0, 5'd9};
    #1 chk("sprwr_same_ack", {31'd0, spr_gpr_ack_o}, 32'd1);
    step(); idle();
    chk("sprwr_same_cycle_rd", rd_dat_o[31:0], 32'h77);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
